// File: rtl/cl_video_pkg.sv
// Shared definitions for the camera-link video to AXI4-Stream bridge:
// framing FSM encoding and the layout of one output FIFO entry.
package cl_video_pkg;

  // Framing states: SYNC waits for the first vblank after reset,
  // WAIT_SOF waits for the first active pixel of a frame,
  // ACTIVE streams pixels until the next vblank rise.
  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2
  } vid_state_e;

  // A FIFO entry is {tuser, tlast, tdata}. tdata occupies the low bits;
  // the sideband offsets below are relative to the pixel width.
  localparam int ENTRY_SIDEBAND_W = 2;
  localparam int ENTRY_TLAST_OFS  = 0;
  localparam int ENTRY_TUSER_OFS  = 1;

  // Total entry width for a given pixel width.
  function automatic int entry_width(input int data_w);
    return data_w + ENTRY_SIDEBAND_W;
  endfunction

endpackage

// File: rtl/cl_sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is visible on rd_data_o
// whenever empty_o is low; pointers carry one extra wrap bit.
module cl_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write into a full FIFO is only taken when the head leaves this cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  // Output is forced to zero when nothing is queued so reset shows all-zero.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage array; contents need no reset because empty gates the output.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/cl_vid_to_axis.sv
// Camera video to AXI4-Stream bridge: frames the pixel stream, marks start
// of frame (tuser) and end of line (tlast), buffers beats in a FIFO and
// reports frame geometry plus a sticky overflow flag.
module cl_vid_to_axis
  import cl_video_pkg::*;
#(
  parameter int VID_DATA_SIZE = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_WIDTH     = 12
) (
  input  logic                     CL_clk,
  input  logic                     CL_reset,
  input  logic                     vid_active_video,
  input  logic [VID_DATA_SIZE-1:0] vid_data,
  input  logic                     vid_hblank,
  input  logic                     vid_vblank,
  output logic [VID_DATA_SIZE-1:0] m_axis_video_tdata,
  output logic                     m_axis_video_tvalid,
  input  logic                     m_axis_video_tready,
  output logic                     m_axis_video_tuser,
  output logic                     m_axis_video_tlast,
  input  logic                     clear_status,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     frame_width,
  output logic [CNT_WIDTH-1:0]     frame_height,
  output logic                     frame_done
);

  localparam int EW        = entry_width(VID_DATA_SIZE);
  localparam int TLAST_BIT = VID_DATA_SIZE + ENTRY_TLAST_OFS;
  localparam int TUSER_BIT = VID_DATA_SIZE + ENTRY_TUSER_OFS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  vid_state_e                state_q, state_d;
  logic                      vblank_q;
  logic                      hold_vld_q, hold_vld_d;
  logic                      hold_sof_q, hold_sof_d;
  logic [VID_DATA_SIZE-1:0]  hold_data_q, hold_data_d;
  logic [CNT_WIDTH-1:0]      pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0]      line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0]      width_q, width_d;
  logic [CNT_WIDTH-1:0]      height_q, height_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;

  logic                      vblank_rise, accept, push, push_last, pop, drop;
  logic                      frame_end, fifo_full, fifo_empty;
  logic [EW-1:0]             push_entry, pop_entry;
  logic                      hblank_unused;

  // Horizontal blank carries no framing information; active video decides.
  assign hblank_unused = vid_hblank;

  assign vblank_rise = vid_vblank && !vblank_q;
  assign accept      = vid_active_video && !vid_vblank && (state_q != ST_SYNC);
  // The held pixel leaves as soon as the next sample is known; it ends the
  // line whenever that sample is not another accepted pixel.
  assign push        = hold_vld_q;
  assign push_last   = !accept;
  assign pop         = m_axis_video_tvalid && m_axis_video_tready;
  assign drop        = push && fifo_full && !pop;
  assign frame_end   = vblank_rise && (state_q == ST_ACTIVE);

  // Framing FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:     if (vid_vblank) state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: if (vid_active_video && !vid_vblank) state_d = ST_ACTIVE;
      ST_ACTIVE:   if (vblank_rise) state_d = ST_WAIT_SOF;
      default:     state_d = ST_SYNC;
    endcase
  end

  // Capture register, counters, frame statistics and overflow next-state.
  always_comb begin
    hold_vld_d  = accept;
    hold_sof_d  = accept && (state_q == ST_WAIT_SOF);
    hold_data_d = accept ? vid_data : hold_data_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    width_d     = width_q;
    height_d    = height_q;
    done_d      = frame_end;

    if (accept) begin
      if (!hold_vld_q)                pix_cnt_d = CNT_ONE;
      else if (pix_cnt_q != CNT_MAX)  pix_cnt_d = pix_cnt_q + CNT_ONE;
    end
    if (push && push_last && (line_cnt_q != CNT_MAX)) line_cnt_d = line_cnt_q + CNT_ONE;

    // The line closed by a held pixel at vblank rise is already in line_cnt_d.
    if (frame_end) begin
      width_d    = pix_cnt_q;
      height_d   = line_cnt_d;
      line_cnt_d = '0;
    end

    // Setting wins over clearing so a drop in the clear cycle is not lost.
    if (drop)              ovf_d = 1'b1;
    else if (clear_status) ovf_d = 1'b0;
    else                   ovf_d = ovf_q;

    push_entry                      = '0;
    push_entry[VID_DATA_SIZE-1:0]   = hold_data_q;
    push_entry[TLAST_BIT]           = push_last;
    push_entry[TUSER_BIT]           = hold_sof_q;
  end

  // State and datapath registers.
  always_ff @(posedge CL_clk or posedge CL_reset) begin
    if (CL_reset) begin
      state_q     <= ST_SYNC;
      vblank_q    <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_sof_q  <= 1'b0;
      hold_data_q <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      width_q     <= '0;
      height_q    <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblank_q    <= vid_vblank;
      hold_vld_q  <= hold_vld_d;
      hold_sof_q  <= hold_sof_d;
      hold_data_q <= hold_data_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      width_q     <= width_d;
      height_q    <= height_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  cl_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CL_clk),
    .rst_i     (CL_reset),
    .wr_en_i   (push),
    .wr_data_i (push_entry),
    .rd_en_i   (m_axis_video_tready),
    .rd_data_o (pop_entry),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign m_axis_video_tvalid = !fifo_empty;
  assign m_axis_video_tdata  = pop_entry[VID_DATA_SIZE-1:0];
  assign m_axis_video_tlast  = pop_entry[TLAST_BIT];
  assign m_axis_video_tuser  = pop_entry[TUSER_BIT];
  assign overflow            = ovf_q;
  assign frame_width         = width_q;
  assign frame_height        = height_q;
  assign frame_done          = done_q;

endmodule

// File: tb/tb_cl_vid_to_axis.sv
// Scoreboard bench for cl_vid_to_axis: frames are described line by line,
// the expected beat list and frame geometry are derived from that
// description, and an independent monitor checks what the DUT emits.
`timescale 1ns/1ps
module tb_cl_vid_to_axis;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 12;

  logic          CL_clk = 1'b0;
  logic          CL_reset = 1'b1;
  logic          vid_active_video = 1'b0;
  logic [W-1:0]  vid_data = '0;
  logic          vid_hblank = 1'b0;
  logic          vid_vblank = 1'b0;
  logic [W-1:0]  m_axis_video_tdata;
  logic          m_axis_video_tvalid;
  logic          m_axis_video_tready = 1'b0;
  logic          m_axis_video_tuser;
  logic          m_axis_video_tlast;
  logic          clear_status = 1'b0;
  logic          overflow;
  logic [CW-1:0] frame_width;
  logic [CW-1:0] frame_height;
  logic          frame_done;

  cl_vid_to_axis #(
    .VID_DATA_SIZE (W),
    .FIFO_DEPTH    (DEPTH),
    .CNT_WIDTH     (CW)
  ) dut (
    .CL_clk              (CL_clk),
    .CL_reset            (CL_reset),
    .vid_active_video    (vid_active_video),
    .vid_data            (vid_data),
    .vid_hblank          (vid_hblank),
    .vid_vblank          (vid_vblank),
    .m_axis_video_tdata  (m_axis_video_tdata),
    .m_axis_video_tvalid (m_axis_video_tvalid),
    .m_axis_video_tready (m_axis_video_tready),
    .m_axis_video_tuser  (m_axis_video_tuser),
    .m_axis_video_tlast  (m_axis_video_tlast),
    .clear_status        (clear_status),
    .overflow            (overflow),
    .frame_width         (frame_width),
    .frame_height        (frame_height),
    .frame_done          (frame_done)
  );

  always #5 CL_clk = ~CL_clk;

  typedef struct packed {
    logic         tuser;
    logic         tlast;
    logic [W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } frm_t;

  beat_t exp_q[$];
  frm_t  frm_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int beat_no  = 0;

  // Reference model state, at frame granularity.
  bit            m_synced   = 1'b0;
  bit            m_in_frame = 1'b0;
  bit            m_ovf      = 1'b0;
  bit            stall_only = 1'b0;
  logic [CW-1:0] m_w, m_h;

  int            tready_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random
  int            line_len[8];
  int            n_lines;
  logic [W-1:0]  next_data;
  bit            rand_data = 1'b0;
  bit            rand_hb   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One sampled video cycle: drive inputs, then step past the next edge.
  task automatic cyc(input bit a, input logic [W-1:0] d, input bit hb, input bit vb);
    vid_active_video = a;
    vid_data         = d;
    vid_hblank       = hb;
    vid_vblank       = vb;
    @(posedge CL_clk);
    #1;
  endtask

  // Expected beat; with tready held low the FIFO content equals exp_q.
  task automatic push_exp(input bit u, input bit l, input logic [W-1:0] d);
    beat_t b;
    b.tuser = u;
    b.tlast = l;
    b.data  = d;
    if (stall_only && exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic vblank_period(input int n);
    frm_t f;
    if (m_in_frame) begin
      f.w = m_w;
      f.h = m_h;
      frm_q.push_back(f);
      m_in_frame = 1'b0;
    end
    m_synced = 1'b1;
    repeat (n) cyc(1'b0, W'($urandom), 1'b1, 1'b1);
  endtask

  // Drive n_lines lines of line_len[] pixels with hblank gaps between them.
  task automatic send_frame(input bit chk_lat, input int gap_after_last);
    bit           take;
    logic [W-1:0] d;
    int           gap;
    take = m_synced;
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < line_len[l]; p++) begin
        if (rand_data) d = W'($urandom);
        else begin
          d = next_data;
          next_data = next_data + 1'b1;
        end
        if (take) push_exp((l == 0) && (p == 0), p == line_len[l] - 1, d);
        cyc(1'b1, d, rand_hb ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
        if (chk_lat && l == 0 && p == 0) check("latency_capture_only", m_axis_video_tvalid, 1'b0);
        if (chk_lat && l == 0 && p == 1) check("latency_two_cycles", m_axis_video_tvalid, 1'b1);
      end
      gap = (l == n_lines - 1) ? gap_after_last : 1 + $urandom_range(0, 2);
      repeat (gap) cyc(1'b0, W'($urandom), 1'b1, 1'b0);
    end
    if (take) begin
      m_in_frame = 1'b1;
      m_w = CW'(line_len[n_lines - 1]);
      m_h = CW'(n_lines);
    end
  endtask

  task automatic drain();
    int budget;
    tready_mode = 1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      @(posedge CL_clk);
      #1;
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge CL_clk);
    #1;
    check("fifo_empty_after_drain", m_axis_video_tvalid, 1'b0);
  endtask

  // tready generator.
  initial begin
    forever begin
      @(posedge CL_clk);
      #1;
      case (tready_mode)
        0:       m_axis_video_tready = 1'b0;
        1:       m_axis_video_tready = 1'b1;
        2:       m_axis_video_tready = ~m_axis_video_tready;
        default: m_axis_video_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, frame_done geometry.
  initial begin
    beat_t cur, prev_beat, e;
    frm_t  f;
    bit    prev_stall, prev_done;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge CL_clk);
      cur = {m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata};
      if (CL_reset) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid_held", m_axis_video_tvalid, 1'b1);
          check("stall_beat_stable", cur, prev_beat);
        end
        if (m_axis_video_tvalid && m_axis_video_tready) begin
          beat_no++;
          $display("beat %0d: tdata=0x%04h tuser=%0d tlast=%0d", beat_no,
                   m_axis_video_tdata, m_axis_video_tuser, m_axis_video_tlast);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", cur);
          end else begin
            e = exp_q.pop_front();
            check("beat", cur, e);
          end
        end
        prev_stall = m_axis_video_tvalid && !m_axis_video_tready;
        prev_beat  = cur;
        if (frame_done) begin
          check("frame_done_one_cycle", prev_done, 1'b0);
          if (frm_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame_done: got pulse w=%0d h=%0d, expected none",
                     frame_width, frame_height);
          end else begin
            f = frm_q.pop_front();
            $display("frame_done: width=%0d height=%0d", frame_width, frame_height);
            check("frame_width", frame_width, f.w);
            check("frame_height", frame_height, f.h);
          end
        end
        prev_done = frame_done;
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with pixels toggling underneath.
    vid_active_video = 1'b1;
    vid_data         = 16'h5A5A;
    #2;
    check("rst_tvalid", m_axis_video_tvalid, 1'b0);
    check("rst_tdata", m_axis_video_tdata, '0);
    check("rst_tuser", m_axis_video_tuser, 1'b0);
    check("rst_tlast", m_axis_video_tlast, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_width", frame_width, '0);
    check("rst_frame_height", frame_height, '0);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (3) @(posedge CL_clk);
    #1;
    CL_reset = 1'b0;

    // Scenario: 3x4 frame, tready high.
    tready_mode = 1;
    vblank_period(4);
    n_lines = 3;
    line_len[0] = 4; line_len[1] = 4; line_len[2] = 4;
    next_data = 16'h0001;
    send_frame(1'b1, 2);
    vblank_period(3);
    check("latched_width", frame_width, 4);
    check("latched_height", frame_height, 3);
    drain();

    // Scenario: same frame fully stalled, then released.
    tready_mode = 0;
    stall_only  = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    next_data = 16'h0001;
    send_frame(1'b0, 2);
    vblank_period(3);
    check("no_overflow_12", overflow, m_ovf);
    check("stalled_tvalid", m_axis_video_tvalid, 1'b1);
    stall_only = 1'b0;
    drain();

    // Scenario: 2x12 stalled, 8 pixels dropped, then clear.
    tready_mode = 0;
    stall_only  = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    n_lines = 2;
    line_len[0] = 12; line_len[1] = 12;
    next_data = 16'h0100;
    send_frame(1'b0, 2);
    vblank_period(3);
    check("overflow_set", overflow, m_ovf);
    stall_only = 1'b0;
    drain();
    check("overflow_sticky", overflow, m_ovf);
    clear_status = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b1);
    clear_status = 1'b0;
    m_ovf = 1'b0;
    check("overflow_cleared", overflow, m_ovf);

    // Scenario: reset released mid-line without a preceding vblank.
    CL_reset   = 1'b1;
    m_synced   = 1'b0;
    m_in_frame = 1'b0;
    exp_q.delete();
    cyc(1'b1, 16'h0A00, 1'b0, 1'b0);
    cyc(1'b1, 16'h0A01, 1'b0, 1'b0);
    CL_reset = 1'b0;
    for (int p = 2; p < 5; p++) cyc(1'b1, W'(16'h0A00 + p), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    n_lines = 2;
    line_len[0] = 4; line_len[1] = 4;
    next_data = 16'h0B00;
    send_frame(1'b0, 2);
    check("sync_no_output", m_axis_video_tvalid, 1'b0);
    vblank_period(3);
    tready_mode = 3;
    next_data = 16'h0C00;
    send_frame(1'b0, 1);
    vblank_period(3);
    drain();

    // Scenario: reset asserted after 6 of 12 pixels have been pushed.
    tready_mode = 0;
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    for (int p = 0; p < 7; p++) cyc(1'b1, W'(16'h0200 + p), 1'b0, 1'b0);
    check("six_stored_tvalid", m_axis_video_tvalid, 1'b1);
    CL_reset = 1'b1;
    #1;
    check("reset_tvalid", m_axis_video_tvalid, 1'b0);
    check("reset_tlast", m_axis_video_tlast, 1'b0);
    m_synced   = 1'b0;
    m_in_frame = 1'b0;
    exp_q.delete();
    cyc(1'b1, 16'h0207, 1'b0, 1'b0);
    check("reset_next_cycle_tvalid", m_axis_video_tvalid, 1'b0);
    CL_reset = 1'b0;
    for (int p = 8; p < 12; p++) cyc(1'b1, W'(16'h0200 + p), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("after_reset_no_beats", m_axis_video_tvalid, 1'b0);
    vblank_period(3);

    // Scenario: 2x8 frame with tready toggling every cycle.
    tready_mode = 2;
    n_lines = 2;
    line_len[0] = 8; line_len[1] = 8;
    next_data = 16'h0300;
    send_frame(1'b0, 2);
    vblank_period(3);
    drain();

    // Randomized frames: random geometry, data, hblank and backpressure.
    rand_data = 1'b1;
    rand_hb   = 1'b1;
    for (int fr = 0; fr < 20; fr++) begin
      tready_mode = 3;
      n_lines = $urandom_range(1, 4);
      for (int l = 0; l < n_lines; l++) line_len[l] = $urandom_range(1, 4);
      send_frame(1'b0, $urandom_range(0, 2));
      vblank_period($urandom_range(1, 3));
      drain();
    end

    repeat (4) cyc(1'b0, '0, 1'b1, 1'b1);
    check("final_frames_outstanding", frm_q.size(), 0);
    check("final_overflow", overflow, m_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cl_vid_to_axis.md
CL_VID_TO_AXIS -- requirements
Module: cl_vid_to_axis

Interface
REQ-001 SHALL have parameter VID_DATA_SIZE, default 16, pixel width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of two, 4..256).
REQ-003 SHALL have parameter CNT_WIDTH, default 12, width of the pixel and line counters.
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
- CL_clk  in  1  sole clock, camera pixel clock.
- CL_reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have these video inputs:
- vid_active_video  in  1  pixel valid.
- vid_data  in  VID_DATA_SIZE  pixel.
- vid_hblank  in  1  horizontal blank.
- vid_vblank  in  1  vertical blank.
REQ-006 SHALL have these AXI4-Stream outputs:
- m_axis_video_tdata  out  VID_DATA_SIZE  pixel.
- m_axis_video_tvalid  out  1  data valid.
- m_axis_video_tready  in  1  consumer ready.
- m_axis_video_tuser  out  1  start of frame.
- m_axis_video_tlast  out  1  end of line.
REQ-007 SHALL have these status and control ports:
- clear_status  in  1  clears overflow.
- overflow  out  1  sticky pixel-drop flag.
- frame_width  out  CNT_WIDTH  pixels in last line of last frame.
- frame_height  out  CNT_WIDTH  lines in last frame.
- frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-008 SHALL implement FSM states SYNC, WAIT_SOF and ACTIVE:
- SYNC -> WAIT_SOF when vid_vblank=1.
- WAIT_SOF -> ACTIVE on first cycle with vid_active_video=1 and vid_vblank=0.
- ACTIVE -> WAIT_SOF on vid_vblank 0->1.
REQ-009 SHALL ignore all input pixels while in SYNC, so that no partial frame after reset is emitted.
REQ-010 SHALL hold each accepted pixel in a one-entry capture register, with these outcomes:
- The held pixel SHALL be pushed with tlast=0 when the next cycle has vid_active_video=1.
- The held pixel SHALL be pushed with tlast=1 when the next cycle has vid_active_video=0.
REQ-011 SHALL set tuser=1 only on the first pixel pushed after the WAIT_SOF->ACTIVE transition, and 0 otherwise.
REQ-012 SHALL make each FIFO entry {tuser, tlast, tdata}; FIFO latency SHALL be 2 cycles from vid_active_video sample to tvalid at earliest (capture + FIFO write).
REQ-013 SHALL apply AXI4-Stream handshake rules:
- Pop only when tvalid=1 and tready=1.
- tdata, tuser and tlast SHALL stay stable while tvalid=1 and tready=0.
- tvalid SHALL NOT depend combinationally on tready.
REQ-014 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle.
REQ-015 SHALL otherwise drop a push to a full FIFO, set overflow=1 and keep it set until clear_status=1.
REQ-016 SHALL give overflow set priority over clear_status in the same cycle.
REQ-017 SHALL treat read/write pointers as log2(FIFO_DEPTH)+1 bits wrapping naturally, with full/empty derived from the MSB difference.
REQ-018 SHALL count pixels per line (reset at each line's first pixel) and lines per frame (incremented per tlast push), with both counters saturating at all-ones.
REQ-019 SHALL, on vid_vblank 0->1 in ACTIVE, latch frame_width and frame_height, pulse frame_done for 1 cycle and clear the line counter.
REQ-020 SHALL handle a vid_vblank rise while a pixel is held by pushing that pixel with tlast=1 before the counter latch, so that the latched height includes that line.
REQ-021 SHALL not look at vid_hblank for framing; vid_hblank=1 with vid_active_video=1 SHALL be treated as active.

Reset
REQ-022 SHALL, while CL_reset=1, force every output to 0 (tvalid, tdata, tuser, tlast, overflow, frame_width, frame_height, frame_done), empty the FIFO, clear the capture register and counters, and set the FSM to SYNC.
REQ-023 SHALL, on reset asserted mid-frame, discard the partial frame; no tlast SHALL be emitted for it.

Structure
REQ-024 SHALL place FSM state encodings and the FIFO entry field offsets in shared package cl_video_pkg.
REQ-025 SHALL implement the FIFO as sub-module cl_sync_fifo (parameterised width and depth, show-ahead output); framing, counters and FSM SHALL remain in cl_vid_to_axis.

Verification
REQ-026 SHALL cover these directed scenarios:
- Reset, vblank, then 3 lines x 4 pixels (data 0x0001..0x000C), tready=1 -> 12 beats, tuser only on 0x0001, tlast on 0x0004/0x0008/0x000C; at vblank rise frame_width=4, frame_height=3, frame_done one cycle.
- Same frame with tready=0 throughout, FIFO_DEPTH=16 -> 12 entries stored, overflow stays 0; then tready=1 -> all 12 delivered in order.
- 2 lines x 12 pixels with tready=0 -> first 16 kept, 8 dropped, overflow=1; clear_status pulse -> overflow=0.
- Reset released mid-active-line (no preceding vblank) -> no beats until after the next vblank; next frame's first beat has tuser=1.
- CL_reset asserted after 6 of 12 pixels pushed -> tvalid=0 next cycle, FIFO empty, no tlast emitted.
- tready toggled 1/0 every cycle during a 2x8 frame -> tdata stable while stalled; 16 beats, tlast on beats 8 and 16.
